dram_cmd_sequencer: RTL and testbench

- Downstream consumer of dram_buffer, the 8-bit request FIFO.
- Pops request bytes, decodes each request and issues closed-page DRAM commands (ACT, RD/WR, PRE) with programmable timing.
- Schedules periodic refresh (REF) between requests.
- Returns read data to the requester with a one-cycle valid strobe.

---
 rtl/dram_cmd_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dram_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_sequencer.sv
// Closed-page DRAM command sequencer: pops requests from the 8-bit request FIFO,
// issues ACT / RD|WR / PRE with programmable timing, and interleaves periodic REF.
module dram_cmd_sequencer #(
  parameter int T_RCD  = 2,
  parameter int T_RAS  = 5,
  parameter int T_RP   = 2,
  parameter int T_CL   = 2,
  parameter int T_RFC  = 4,
  parameter int T_REFI = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dataout,
  output logic       fifo_rd_en,
  output logic [2:0] dram_cmd,
  output logic [3:0] dram_row,
  output logic [2:0] dram_col,
  output logic [7:0] dram_wdata,
  input  logic [7:0] dram_rdata,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy
);

  // PRE may not precede tRAS nor the read return / write completion.
  localparam int PRE_RD = (T_RAS > T_RCD + T_CL + 1) ? T_RAS : T_RCD + T_CL + 1;
  localparam int PRE_WR = (T_RAS > T_RCD + 1) ? T_RAS : T_RCD + 1;
  localparam int MAX_A  = (PRE_RD > T_RP) ? PRE_RD : T_RP;
  localparam int MAX_T  = (MAX_A > T_RFC) ? MAX_A : T_RFC;
  localparam int CNT_W  = $clog2(MAX_T + 1);
  localparam int REF_W  = $clog2(T_REFI);

  localparam logic [CNT_W-1:0] RCD_M1    = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] CAP_AT    = CNT_W'(T_RCD + T_CL);
  localparam logic [CNT_W-1:0] PRE_RD_M1 = CNT_W'(PRE_RD - 1);
  localparam logic [CNT_W-1:0] PRE_WR_M1 = CNT_W'(PRE_WR - 1);
  localparam logic [CNT_W-1:0] RP_M1     = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_M1    = CNT_W'(T_RFC - 1);
  localparam logic [REF_W-1:0] REFI_M1   = REF_W'(T_REFI - 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_HDR, S_WREQ, S_WPOP, S_WLAT, S_ROW, S_PRE, S_REF
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] t_cnt, t_n;
  logic [REF_W-1:0] ref_cnt, ref_cnt_n;
  logic             ref_pend, ref_pend_n;
  logic             we_q;
  logic [3:0]       row_q;
  logic [2:0]       col_q;
  logic [7:0]       wdata_q;

  logic [2:0] cmd_d;
  logic       rd_en_d, rvld_d;
  logic [3:0] row_d;
  logic [2:0] col_d;
  logic [7:0] wdata_d, rdata_d;

  logic ref_wrap, ref_due, at_idle, go_ref, go_pop, hdr_we;
  logic act_now, rw_now, cap_now, pre_now, wpop_now;

  // The end of a PRE/REF wait behaves exactly like IDLE so no cycle is lost.
  assign ref_wrap = (ref_cnt == REFI_M1);
  assign ref_due  = ref_pend | ref_wrap;
  assign at_idle  = (state == S_IDLE) ||
                    (state == S_PRE && t_cnt == RP_M1) ||
                    (state == S_REF && t_cnt == RFC_M1);
  assign go_ref   = at_idle & ref_due;
  assign go_pop   = at_idle & ~ref_due & ~fifo_empty;
  assign hdr_we   = fifo_dataout[7];
  assign act_now  = (state == S_HDR && !hdr_we) || (state == S_WLAT);
  assign rw_now   = (state == S_ROW) && (t_cnt == RCD_M1);
  assign cap_now  = (state == S_ROW) && !we_q && (t_cnt == CAP_AT);
  assign pre_now  = (state == S_ROW) && (t_cnt == (we_q ? PRE_WR_M1 : PRE_RD_M1));
  assign wpop_now = ((state == S_HDR && hdr_we) || state == S_WREQ) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      t_cnt      <= '0;
      ref_cnt    <= '0;
      ref_pend   <= 1'b0;
      fifo_rd_en <= 1'b0;
      dram_cmd   <= CMD_NOP;
      dram_row   <= '0;
      dram_col   <= '0;
      dram_wdata <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      t_cnt      <= t_n;
      ref_cnt    <= ref_cnt_n;
      ref_pend   <= ref_pend_n;
      fifo_rd_en <= rd_en_d;
      dram_cmd   <= cmd_d;
      dram_row   <= row_d;
      dram_col   <= col_d;
      dram_wdata <= wdata_d;
      rd_data    <= rdata_d;
      rd_valid   <= rvld_d;
      busy       <= (state_n != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_HDR) begin
      we_q  <= fifo_dataout[7];
      row_q <= fifo_dataout[6:3];
      col_q <= fifo_dataout[2:0];
    end
    if (state == S_WLAT) wdata_q <= fifo_dataout;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_PRE, S_REF: begin
        if (go_ref)       state_n = S_REF;
        else if (go_pop)  state_n = S_POP;
        else if (at_idle) state_n = S_IDLE;
      end
      S_POP:   state_n = S_HDR;
      S_HDR:   state_n = hdr_we ? (fifo_empty ? S_WREQ : S_WPOP) : S_ROW;
      S_WREQ:  if (!fifo_empty) state_n = S_WPOP;
      S_WPOP:  state_n = S_WLAT;
      S_WLAT:  state_n = S_ROW;
      S_ROW:   if (pre_now) state_n = S_PRE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_d = CMD_NOP;
    if (go_ref)       cmd_d = CMD_REF;
    else if (act_now) cmd_d = CMD_ACT;
    else if (rw_now)  cmd_d = we_q ? CMD_WR : CMD_RD;
    else if (pre_now) cmd_d = CMD_PRE;
    rd_en_d = go_pop | wpop_now;
    row_d   = act_now ? ((state == S_HDR) ? fifo_dataout[6:3] : row_q) : dram_row;
    col_d   = rw_now ? col_q : dram_col;
    wdata_d = (rw_now && we_q) ? wdata_q : dram_wdata;
    rdata_d = cap_now ? dram_rdata : rd_data;
    rvld_d  = cap_now;
    t_n = t_cnt;
    if (go_ref || act_now || pre_now)
      t_n = '0;
    else if (state == S_ROW || state == S_PRE || state == S_REF)
      t_n = t_cnt + CNT_W'(1);
    // A wrap while a refresh is already owed collapses into the one pending.
    ref_cnt_n  = ref_wrap ? '0 : ref_cnt + REF_W'(1);
    ref_pend_n = go_ref ? 1'b0 : (ref_pend | ref_wrap);
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Bench for dram_cmd_sequencer: table of single-request vectors plus directed
// sequences for reset, write-data stall, refresh scheduling and abort.
module tb_dram_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_dataout = 8'h00;
  logic       fifo_rd_en;
  logic [2:0] dram_cmd;
  logic [3:0] dram_row;
  logic [2:0] dram_col;
  logic [7:0] dram_wdata;
  logic [7:0] dram_rdata = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  always #5 clk = ~clk;

  dram_cmd_sequencer dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
    .fifo_rd_en(fifo_rd_en), .dram_cmd(dram_cmd), .dram_row(dram_row),
    .dram_col(dram_col), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cyc0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Request FIFO model: dataout is valid the cycle after a pop.
  logic [7:0] mem [0:255];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  int underflow = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wp == rp) underflow <= underflow + 1;
      fifo_dataout <= mem[rp];
      rp <= rp + 8'd1;
    end
  end

  // DRAM model: read data is presented only in cycle tRD+2.
  logic [7:0] rd_val = 8'h00;
  int rd_at = -100;
  always @(negedge clk) begin
    if (dram_cmd == 3'd2) rd_at <= cyc + 2;
    dram_rdata <= (cyc == rd_at) ? rd_val : 8'h00;
  end

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] wdat;
    bit         follow;
    logic [7:0] rdata;
    int e_act, e_row, e_rw, e_cmd, e_col, e_wdata;
    int e_rvcnt, e_rvoff, e_rvdata, e_pre, e_pop2, e_pop3, e_idle;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 8'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic run_vec(input int i, input bit with_reset);
    int act_off, act_row, rw_off, rw_cmd, rw_col, rw_wdata;
    int rv_cnt, rv_off, rv_data, pre_off, idle_off, np;
    int pops [3];
    bit found;
    if (with_reset) do_reset();
    rd_val = tbl[i].rdata;
    push(tbl[i].hdr);
    if (tbl[i].hdr[7]) push(tbl[i].wdat);
    if (tbl[i].follow) push(8'h00);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      found = fifo_rd_en;
    end
    chk($sformatf("v%0d_first_pop", i), int'(found), 1);
    if (!found) return;
    act_off = -1; act_row = -1; rw_off = -1; rw_cmd = -1; rw_col = -1; rw_wdata = -1;
    rv_cnt = 0; rv_off = -1; rv_data = -1; pre_off = -1; idle_off = -1; np = 0;
    pops[0] = -1; pops[1] = -1; pops[2] = -1;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      if (fifo_rd_en && np < 3) begin pops[np] = k; np++; end
      if (dram_cmd == 3'd1 && act_off < 0) begin act_off = k; act_row = int'(dram_row); end
      if ((dram_cmd == 3'd2 || dram_cmd == 3'd3) && rw_off < 0) begin
        rw_off = k; rw_cmd = int'(dram_cmd); rw_col = int'(dram_col); rw_wdata = int'(dram_wdata);
      end
      if (rd_valid) begin
        rv_cnt++;
        if (rv_off < 0) begin rv_off = k; rv_data = int'(rd_data); end
      end
      if (dram_cmd == 3'd4 && pre_off < 0) pre_off = k;
      if (!busy && idle_off < 0) idle_off = k;
    end
    chk($sformatf("v%0d_act_off", i),  act_off, tbl[i].e_act);
    chk($sformatf("v%0d_act_row", i),  act_row, tbl[i].e_row);
    chk($sformatf("v%0d_rw_off", i),   rw_off,  tbl[i].e_rw);
    chk($sformatf("v%0d_rw_cmd", i),   rw_cmd,  tbl[i].e_cmd);
    chk($sformatf("v%0d_rw_col", i),   rw_col,  tbl[i].e_col);
    if (tbl[i].hdr[7]) chk($sformatf("v%0d_wdata", i), rw_wdata, tbl[i].e_wdata);
    chk($sformatf("v%0d_rv_cnt", i),   rv_cnt,  tbl[i].e_rvcnt);
    chk($sformatf("v%0d_rv_off", i),   rv_off,  tbl[i].e_rvoff);
    if (!tbl[i].hdr[7]) chk($sformatf("v%0d_rd_data", i), rv_data, tbl[i].e_rvdata);
    chk($sformatf("v%0d_pre_off", i),  pre_off, tbl[i].e_pre);
    chk($sformatf("v%0d_pop2_off", i), pops[1], tbl[i].e_pop2);
    chk($sformatf("v%0d_pop3_off", i), pops[2], tbl[i].e_pop3);
    chk($sformatf("v%0d_idle_off", i), idle_off, tbl[i].e_idle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ref, second_ref, n_ref, off, viol, quiet;
    int d_pop1, d_pop2, d_act, d_pre, d_ref;
    bit found;

    //        hdr    wdat   fol  rdata  act row rw cmd col wdata rvc rvoff rvdata pre pop2 pop3 idle
    tbl[0] = '{8'h35, 8'h00, 1'b1, 8'hA5, 2, 6,  4, 2, 5, 0,    1, 7,  'hA5, 7, 9,  -1, -1};
    tbl[1] = '{8'h9A, 8'h5C, 1'b0, 8'h00, 4, 3,  6, 3, 2, 'h5C, 0, -1, 0,    9, 2,  -1, 11};
    tbl[2] = '{8'h7F, 8'h00, 1'b0, 8'h3C, 2, 15, 4, 2, 7, 0,    1, 7,  'h3C, 7, -1, -1, 9};
    tbl[3] = '{8'h80, 8'hFF, 1'b1, 8'h00, 4, 0,  6, 3, 0, 'hFF, 0, -1, 0,    9, 2,  11, -1};
    tbl[4] = '{8'h4B, 8'h00, 1'b1, 8'h81, 2, 9,  4, 2, 3, 0,    1, 7,  'h81, 7, 9,  -1, -1};

    // Reset held with a non-empty FIFO: everything stays quiet.
    push(8'h35);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_rd_en", k), int'(fifo_rd_en), 0);
      chk($sformatf("rst%0d_cmd", k),   int'(dram_cmd), 0);
      chk($sformatf("rst%0d_rvld", k),  int'(rd_valid), 0);
      chk($sformatf("rst%0d_busy", k),  int'(busy), 0);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i, 1'b1);

    // Write header with no data byte behind it.
    do_reset();
    push(8'h9A);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      found = fifo_rd_en;
    end
    chk("stall_hdr_pop", int'(found), 1);
    off = cyc;
    viol = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dram_cmd != 3'd0 || fifo_rd_en || !busy) viol++;
    end
    chk("stall_viol", viol, 0);
    push(8'h11);
    found = 1'b0;
    for (int w = 0; w < 5 && !found; w++) begin
      @(negedge clk);
      found = fifo_rd_en;
    end
    chk("stall_data_pop_off", cyc - off, 11);
    repeat (2) @(negedge clk);
    chk("stall_act_cmd", int'(dram_cmd), 1);
    chk("stall_act_row", int'(dram_row), 3);
    repeat (2) @(negedge clk);
    chk("stall_wr_cmd", int'(dram_cmd), 3);
    chk("stall_wr_col", int'(dram_col), 2);
    chk("stall_wr_wdata", int'(dram_wdata), 'h11);

    // Idle refresh cadence.
    do_reset();
    first_ref = -1; second_ref = -1; n_ref = 0;
    for (int k = 1; k <= 135; k++) begin
      @(negedge clk);
      if (dram_cmd == 3'd5) begin
        if (first_ref < 0) first_ref = cyc - cyc0;
        else if (second_ref < 0) second_ref = cyc - cyc0;
        n_ref++;
      end
    end
    chk("ref_idle_first", first_ref, 64);
    chk("ref_idle_second", second_ref, 128);
    chk("ref_idle_count", n_ref, 2);

    // Refresh maturing in the middle of a read.
    do_reset();
    rd_val = 8'h5A;
    repeat (58) @(negedge clk);
    push(8'h35);
    push(8'h21);
    d_pop1 = -1; d_pop2 = -1; d_act = -1; d_pre = -1; d_ref = -1;
    for (int k = 59; k <= 80; k++) begin
      @(negedge clk);
      off = cyc - cyc0;
      if (fifo_rd_en) begin
        if (d_pop1 < 0) d_pop1 = off;
        else if (d_pop2 < 0) d_pop2 = off;
      end
      if (dram_cmd == 3'd1 && d_act < 0) d_act = off;
      if (dram_cmd == 3'd4 && d_pre < 0) d_pre = off;
      if (dram_cmd == 3'd5 && d_ref < 0) d_ref = off;
    end
    chk("refmid_pop1", d_pop1, 59);
    chk("refmid_act", d_act, 61);
    chk("refmid_pre", d_pre, 66);
    chk("refmid_ref", d_ref, 68);
    chk("refmid_pop2", d_pop2, 72);

    // Reset the cycle after ACT aborts the request without a PRE.
    do_reset();
    push(8'h35);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge clk);
      found = (dram_cmd == 3'd1);
    end
    chk("abort_act_seen", int'(found), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cmd", int'(dram_cmd), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    cyc0 = cyc;
    quiet = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dram_cmd != 3'd0 || busy) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    run_vec(0, 1'b0);

    chk("fifo_underflow", underflow, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
